// File: rtl/nibble_serial_adder.sv
//------------------------------------------------------------------------------
// nibble_serial_adder
//
// Purpose:
//   Multi-cycle WIDTH-bit adder. It feeds the operands four bits at a time
//   through a single 4-bit carry-lookahead slice (CarryLookaheadAdder4bits).
//   The carry between slices is registered, and the full sum is assembled in
//   a right-shifting register. A result therefore takes N = WIDTH/4 cycles
//   instead of needing a full-width adder.
//
// Parameters:
//   WIDTH        operand width in bits; a multiple of 4 and at least 8
//
// Ports:
//   clk          clock; all state updates happen on the rising edge
//   rst_n        asynchronous active-low reset
//   in_valid_i   operand offer from the issue logic
//   in_ready_o   block can accept operands (only in IDLE)
//   a_i, b_i     operands, WIDTH bits each
//   c_in_i       carry into bit 0
//   out_valid_o  result available (only in DONE)
//   out_ready_i  consumer accepts the result
//   sum_o        low WIDTH bits of a + b + c_in
//   c_out_o      carry out of bit WIDTH-1
//   overflow_o   two's-complement overflow of the addition
//------------------------------------------------------------------------------

// Plain 4-bit carry-lookahead slice: every carry is computed directly from
// generate/propagate terms, so there is no ripple inside the nibble.
module CarryLookaheadAdder4bits (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       c_o
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  assign c[0] = c_i;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign s_o = p ^ c[3:0];
  assign c_o = c[4];

endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             c_in_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             c_out_o,
  output logic             overflow_o
);

  localparam int N  = WIDTH / 4;
  localparam int CW = $clog2(N);

  localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q,    state_d;
  logic [CW-1:0]    cnt_q,      cnt_d;
  logic [WIDTH-1:0] aSh_q,      aSh_d;
  logic [WIDTH-1:0] bSh_q,      bSh_d;
  logic             carry_q,    carry_d;
  logic [WIDTH-1:0] sum_q,      sum_d;
  logic             cOut_q,     cOut_d;
  logic             ovf_q,      ovf_d;
  logic             inReady_q,  inReady_d;
  logic             outValid_q, outValid_d;

  logic [3:0] sliceSum;
  logic       sliceCout;
  logic       msbCarryIn;

  // The operand shift registers always present the current nibble in their
  // low four bits, so the slice never needs a nibble multiplexer.
  CarryLookaheadAdder4bits uSlice (
    .a_i (aSh_q[3:0]),
    .b_i (bSh_q[3:0]),
    .c_i (carry_q),
    .s_o (sliceSum),
    .c_o (sliceCout)
  );

  // Carry into the top bit of the slice, recovered from the sum bit:
  // s = a ^ b ^ cin  =>  cin = s ^ a ^ b. Only meaningful on the last step,
  // where that bit is the MSB of the whole word.
  assign msbCarryIn = sliceSum[3] ^ aSh_q[3] ^ bSh_q[3];

  // Next-state logic. Everything holds by default; IDLE latches a new
  // request, RUN advances one nibble per cycle, DONE waits for the consumer.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    aSh_d    = aSh_q;
    bSh_d    = bSh_q;
    carry_d  = carry_q;
    sum_d    = sum_q;
    cOut_d   = cOut_q;
    ovf_d    = ovf_q;

    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          aSh_d   = a_i;
          bSh_d   = b_i;
          carry_d = c_in_i;
          cnt_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        aSh_d   = {4'b0000, aSh_q[WIDTH-1:4]};
        bSh_d   = {4'b0000, bSh_q[WIDTH-1:4]};
        // New nibble enters at the top; after N steps the first nibble has
        // reached bits 3..0 and the word is in its final position.
        sum_d   = {sliceSum, sum_q[WIDTH-1:4]};
        carry_d = sliceCout;
        if (cnt_q == LAST_STEP) begin
          cOut_d  = sliceCout;
          ovf_d   = msbCarryIn ^ sliceCout;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      DONE: begin
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Handshake flags are flops decoded from the next state, so neither output
  // has a combinational path from in_valid_i or out_ready_i.
  always_comb begin
    inReady_d  = (state_d == IDLE);
    outValid_d = (state_d == DONE);
  end

  // State registers. Reset discards any operation in flight and returns
  // every visible output to its idle value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      aSh_q      <= '0;
      bSh_q      <= '0;
      carry_q    <= 1'b0;
      sum_q      <= '0;
      cOut_q     <= 1'b0;
      ovf_q      <= 1'b0;
      inReady_q  <= 1'b1;
      outValid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      aSh_q      <= aSh_d;
      bSh_q      <= bSh_d;
      carry_q    <= carry_d;
      sum_q      <= sum_d;
      cOut_q     <= cOut_d;
      ovf_q      <= ovf_d;
      inReady_q  <= inReady_d;
      outValid_q <= outValid_d;
    end
  end

  assign in_ready_o  = inReady_q;
  assign out_valid_o = outValid_q;
  assign sum_o       = sum_q;
  assign c_out_o     = cOut_q;
  assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
//------------------------------------------------------------------------------
// tb_nibble_serial_adder
//
// Self-checking bench for nibble_serial_adder. A 32-bit instance covers the
// directed vector table, backpressure, mid-operation reset, issue interval
// and random traffic; an 8-bit instance covers the narrowest legal width.
//------------------------------------------------------------------------------
module tb_nibble_serial_adder;

  logic        clk;
  logic        rst_n;

  logic        inValid;
  logic        inReady;
  logic [31:0] a;
  logic [31:0] b;
  logic        cIn;
  logic        outValid;
  logic        outReady;
  logic [31:0] sum;
  logic        cOut;
  logic        ovf;

  logic        inValid8;
  logic        inReady8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic        cIn8;
  logic        outValid8;
  logic        outReady8;
  logic [7:0]  sum8;
  logic        cOut8;
  logic        ovf8;

  int checks;
  int errors;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs[8];

  nibble_serial_adder #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (inValid),
    .in_ready_o  (inReady),
    .a_i         (a),
    .b_i         (b),
    .c_in_i      (cIn),
    .out_valid_o (outValid),
    .out_ready_i (outReady),
    .sum_o       (sum),
    .c_out_o     (cOut),
    .overflow_o  (ovf)
  );

  nibble_serial_adder #(.WIDTH(8)) dut8 (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (inValid8),
    .in_ready_o  (inReady8),
    .a_i         (a8),
    .b_i         (b8),
    .c_in_i      (cIn8),
    .out_valid_o (outValid8),
    .out_ready_i (outReady8),
    .sum_o       (sum8),
    .c_out_o     (cOut8),
    .overflow_o  (ovf8)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case some wait is never satisfied
  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  // One comparison: counts it, reports a FAIL line on mismatch
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Runs one full operation on the 32-bit instance. Called at a negedge and
  // returns at a negedge. lat counts rising edges from accept to out_valid.
  task automatic applyStimulus(input logic [31:0] av, input logic [31:0] bv, input logic cv,
                               input int gap, output logic [31:0] s, output logic co,
                               output logic ov, output int lat);
    int w;
    s   = '0;
    co  = 1'b0;
    ov  = 1'b0;
    lat = -1;
    repeat (gap) @(negedge clk);
    a       = av;
    b       = bv;
    cIn     = cv;
    inValid = 1'b1;
    w = 0;
    while (!inReady && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!inReady) begin
      checkOutput("accept_timeout", 64'(inReady), 64'd1);
      inValid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    inValid = 1'b0;
    a       = $urandom;
    b       = $urandom;
    cIn     = 1'($urandom_range(0, 1));
    lat = 0;
    while (lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
      if (outValid) break;
    end
    if (!outValid) begin
      checkOutput("result_timeout", 64'(outValid), 64'd1);
      return;
    end
    s  = sum;
    co = cOut;
    ov = ovf;
    @(negedge clk);
    outReady = 1'b1;
    @(posedge clk);
    #1;
    outReady = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] s;
    logic        co;
    logic        ov;
    int          lat;
    logic [32:0] full;
    logic        ovfRef;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rc;
    int          lastAccept;
    int          accepts;
    logic        sawValid;

    checks = 0;
    errors = 0;

    vecs[0] = '{"ripple_all",   32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vecs[1] = '{"signed_ovf",   32'h7FFFFFFF, 32'h00000000, 1'b1, 32'h80000000, 1'b0, 1'b1};
    vecs[2] = '{"plain_add",    32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0};
    vecs[3] = '{"neg_ovf",      32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
    vecs[4] = '{"zero_cin",     32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 1'b0, 1'b0};
    vecs[5] = '{"all_ones_cin", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};
    vecs[6] = '{"alt_nibbles",  32'h0F0F0F0F, 32'hF0F0F0F0, 1'b1, 32'h00000000, 1'b1, 1'b0};
    vecs[7] = '{"no_carry",     32'h89ABCDEF, 32'h76543210, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0};

    rst_n     = 1'b0;
    inValid   = 1'b0;
    outReady  = 1'b0;
    a         = '0;
    b         = '0;
    cIn       = 1'b0;
    inValid8  = 1'b0;
    outReady8 = 1'b0;
    a8        = '0;
    b8        = '0;
    cIn8      = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst_in_ready",    64'(inReady),  64'd1);
    checkOutput("rst_out_valid",   64'(outValid), 64'd0);
    checkOutput("rst_sum",         64'(sum),      64'd0);
    checkOutput("rst_c_out",       64'(cOut),     64'd0);
    checkOutput("rst_overflow",    64'(ovf),      64'd0);
    checkOutput("rst_in_ready8",   64'(inReady8), 64'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vector table
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin, 0, s, co, ov, lat);
      checkOutput({vecs[i].name, "_sum"},     64'(s),   64'(vecs[i].sum));
      checkOutput({vecs[i].name, "_c_out"},   64'(co),  64'(vecs[i].cout));
      checkOutput({vecs[i].name, "_ovf"},     64'(ov),  64'(vecs[i].ovf));
      checkOutput({vecs[i].name, "_latency"}, 64'(lat), 64'd8);
    end

    // Backpressure with in_valid pulses during RUN and DONE
    a = 32'h12345678; b = 32'h11111111; cIn = 1'b0; inValid = 1'b1;
    @(posedge clk);
    #1;
    inValid = 1'b0;
    a = 32'hDEADBEEF; b = 32'hCAFEF00D;
    lat = 0;
    while (lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
      inValid = (lat >= 2 && lat <= 4);
      if (!outValid) checkOutput("bp_run_in_ready", 64'(inReady), 64'd0);
      if (outValid) break;
    end
    checkOutput("bp_latency", 64'(lat), 64'd8);
    for (int k = 0; k < 5; k++) begin
      inValid = (k % 2 == 0);
      @(negedge clk);
      checkOutput("bp_hold_sum",       64'(sum),      64'h23456789);
      checkOutput("bp_hold_out_valid", 64'(outValid), 64'd1);
      checkOutput("bp_hold_in_ready",  64'(inReady),  64'd0);
    end
    inValid  = 1'b0;
    outReady = 1'b1;
    @(posedge clk);
    #1;
    outReady = 1'b0;
    checkOutput("bp_release_in_ready",  64'(inReady),  64'd1);
    checkOutput("bp_release_out_valid", 64'(outValid), 64'd0);
    sawValid = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (outValid) sawValid = 1'b1;
    end
    checkOutput("bp_no_second_op", 64'(sawValid), 64'd0);

    // Reset three cycles into RUN
    a = 32'hFFFFFFFF; b = 32'h00000001; cIn = 1'b0; inValid = 1'b1;
    @(posedge clk);
    #1;
    inValid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_in_ready",  64'(inReady),  64'd1);
    checkOutput("mid_rst_out_valid", 64'(outValid), 64'd0);
    checkOutput("mid_rst_sum",       64'(sum),      64'd0);
    checkOutput("mid_rst_c_out",     64'(cOut),     64'd0);
    checkOutput("mid_rst_overflow",  64'(ovf),      64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    sawValid = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (outValid) sawValid = 1'b1;
    end
    checkOutput("mid_rst_no_result", 64'(sawValid), 64'd0);
    applyStimulus(32'd3, 32'd4, 1'b0, 0, s, co, ov, lat);
    checkOutput("post_rst_sum", 64'(s), 64'd7);

    // Continuous in_valid: accepts must be exactly 10 cycles apart
    a = 32'h0000FFFF; b = 32'h00000001; cIn = 1'b0;
    inValid = 1'b1;
    outReady = 1'b1;
    lastAccept = -1;
    accepts = 0;
    for (int cyc = 0; cyc < 42; cyc++) begin
      if (inReady) begin
        if (lastAccept >= 0) checkOutput("issue_interval", 64'(cyc - lastAccept), 64'd10);
        lastAccept = cyc;
        accepts++;
      end
      if (outValid) checkOutput("issue_sum", 64'(sum), 64'h00010000);
      @(negedge clk);
    end
    inValid = 1'b0;
    checkOutput("issue_accept_count", 64'(accepts >= 4), 64'd1);
    repeat (12) @(negedge clk);
    outReady = 1'b0;
    @(negedge clk);

    // Random traffic with random gaps
    for (int n = 0; n < 1000; n++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(0, 1));
      if (n % 4 == 0) begin
        ra[31] = 1'b0;
        rb[31] = 1'b0;
      end
      full   = {1'b0, ra} + {1'b0, rb} + 33'(rc);
      ovfRef = (ra[31] == rb[31]) && (full[31] != ra[31]);
      applyStimulus(ra, rb, rc, $urandom_range(0, 2), s, co, ov, lat);
      checkOutput("rand_sum_cout", {31'd0, co, s}, 64'(full));
      checkOutput("rand_ovf", 64'(ov), 64'(ovfRef));
    end

    // 8-bit instance: two nibbles, two-cycle latency
    a8 = 8'h80; b8 = 8'h80; cIn8 = 1'b0; inValid8 = 1'b1;
    @(posedge clk);
    #1;
    inValid8 = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (outValid8) break;
    end
    checkOutput("w8_latency", 64'(lat),   64'd2);
    checkOutput("w8_sum",     64'(sum8),  64'h00);
    checkOutput("w8_c_out",   64'(cOut8), 64'd1);
    checkOutput("w8_ovf",     64'(ovf8),  64'd1);
    @(negedge clk);
    outReady8 = 1'b1;
    @(posedge clk);
    #1;
    outReady8 = 1'b0;
    checkOutput("w8_release_in_ready", 64'(inReady8), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
